operand_fetch_stage: RTL and testbench

Decode/operand-fetch stage that sits directly upstream of the 8-bit ALU. It decodes one 32-bit instruction per cycle and reads two operands from an internal 8x8 register file. It applies immediate select and two's-complement negation, then registers DATA1, DATA2 and ALUOP for the ALU. The ALU result is written back through a dedicated write port, with same-cycle write-to-read bypass.

---
 rtl/cpu_pkg.sv | 46 ++++
 rtl/reg_file_8x8.sv | 43 ++++
 rtl/operand_fetch_stage.sv | 132 +++++++++++++
 tb/tb_operand_fetch_stage.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// cpu_pkg: shared constants, instruction field layout and stage output record for the operand fetch stage
package cpu_pkg;

    localparam int DATA_W   = 8;
    localparam int NUM_REGS = 8;
    localparam int ADDR_W   = 3;

    localparam int OPC_MSB = 31;
    localparam int OPC_LSB = 24;
    localparam int RD_LSB  = 16;
    localparam int RT_LSB  = 8;
    localparam int RS_LSB  = 0;

    localparam logic [7:0] OP_LOADI = 8'd0;
    localparam logic [7:0] OP_MOV   = 8'd1;
    localparam logic [7:0] OP_ADD   = 8'd2;
    localparam logic [7:0] OP_SUB   = 8'd3;
    localparam logic [7:0] OP_AND   = 8'd4;
    localparam logic [7:0] OP_OR    = 8'd5;
    localparam logic [7:0] OP_J     = 8'd6;
    localparam logic [7:0] OP_BEQ   = 8'd7;

    localparam logic [2:0] ALU_FWD = 3'b000;
    localparam logic [2:0] ALU_ADD = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;

    typedef struct packed {
        logic [DATA_W-1:0] data1;
        logic [DATA_W-1:0] data2;
        logic [2:0]        aluop;
        logic [ADDR_W-1:0] dest_addr;
        logic              dest_we;
        logic              branch;
        logic              jump;
        logic [7:0]        offset;
        logic              valid;
        logic              illegal;
    } stage_out_t;

    // two's complement; 0x80 maps to itself, 0x00 to itself
    function automatic logic [DATA_W-1:0] negate(input logic [DATA_W-1:0] v);
        return ~v + {{(DATA_W-1){1'b0}}, 1'b1};
    endfunction

endpackage

// File: rtl/reg_file_8x8.sv
// reg_file_8x8: 8x8 register file, two async read ports with write-first bypass, one sync write port
// Ports: clk, rst (async active-high), we/waddr/wdata write port,
//        raddr_a/rdata_a and raddr_b/rdata_b read ports.
// Optional macro OFS_ZERO_REG_EN: R0 reads as zero, writes to it are dropped and never bypassed.
import cpu_pkg::*;

module reg_file_8x8 (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr_a,
    input  logic [ADDR_W-1:0] raddr_b,
    output logic [DATA_W-1:0] rdata_a,
    output logic [DATA_W-1:0] rdata_b
);

    logic [DATA_W-1:0] regs_q [NUM_REGS];
    logic [DATA_W-1:0] regs_d [NUM_REGS];
    logic              wr_ok;

`ifdef OFS_ZERO_REG_EN
    // R0 is never written, so its reset value of zero persists
    assign wr_ok = we && (waddr != '0);
`else
    assign wr_ok = we;
`endif

    always_comb begin
        regs_d = regs_q;
        if (wr_ok) regs_d[waddr] = wdata;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) regs_q <= '{default: '0};
        else     regs_q <= regs_d;
    end

    assign rdata_a = (wr_ok && waddr == raddr_a) ? wdata : regs_q[raddr_a];
    assign rdata_b = (wr_ok && waddr == raddr_b) ? wdata : regs_q[raddr_b];

endmodule

// File: rtl/operand_fetch_stage.sv
// operand_fetch_stage: decodes one instruction per cycle, fetches operands and registers them for the ALU
// Ports: CLK, RESET (async active-high); INSTRUCTION/INSTR_VALID in; STALL holds outputs;
//        WB_EN/WB_ADDR/WB_DATA write-back port; DATA1/DATA2/ALUOP/DEST_ADDR/DEST_WE/
//        BRANCH/JUMP/OFFSET/OUT_VALID/ILLEGAL registered outputs.
// Optional macro OFS_ZERO_REG_EN (inside reg_file_8x8): R0 hardwired to zero.
import cpu_pkg::*;

module operand_fetch_stage (
    input  logic        CLK,
    input  logic        RESET,
    input  logic [31:0] INSTRUCTION,
    input  logic        INSTR_VALID,
    input  logic        STALL,
    input  logic        WB_EN,
    input  logic [2:0]  WB_ADDR,
    input  logic [7:0]  WB_DATA,
    output logic [7:0]  DATA1,
    output logic [7:0]  DATA2,
    output logic [2:0]  ALUOP,
    output logic [2:0]  DEST_ADDR,
    output logic        DEST_WE,
    output logic        BRANCH,
    output logic        JUMP,
    output logic [7:0]  OFFSET,
    output logic        OUT_VALID,
    output logic        ILLEGAL
);

    logic [7:0]        opcode;
    logic [7:0]        field_rd;
    logic [7:0]        imm;
    logic [ADDR_W-1:0] addr_rd;
    logic [ADDR_W-1:0] addr_rt;
    logic [ADDR_W-1:0] addr_rs;
    logic [DATA_W-1:0] val_rt;
    logic [DATA_W-1:0] val_rs;
    logic [DATA_W-1:0] neg_rs;
    logic              unused_rt_hi;
    stage_out_t        out_d;
    stage_out_t        out_q;

    assign opcode   = INSTRUCTION[OPC_MSB:OPC_LSB];
    assign field_rd = INSTRUCTION[RD_LSB +: 8];
    assign imm      = INSTRUCTION[RS_LSB +: 8];
    assign addr_rd  = INSTRUCTION[RD_LSB +: ADDR_W];
    assign addr_rt  = INSTRUCTION[RT_LSB +: ADDR_W];
    assign addr_rs  = INSTRUCTION[RS_LSB +: ADDR_W];
    assign unused_rt_hi = ^INSTRUCTION[15:11];

    reg_file_8x8 u_rf (
        .clk     (CLK),
        .rst     (RESET),
        .we      (WB_EN),
        .waddr   (WB_ADDR),
        .wdata   (WB_DATA),
        .raddr_a (addr_rt),
        .raddr_b (addr_rs),
        .rdata_a (val_rt),
        .rdata_b (val_rs)
    );

    // negation follows the bypass so a same-cycle write-back is negated too
    assign neg_rs = negate(val_rs);

    always_comb begin
        out_d = out_q;
        if (!STALL) begin
            out_d = '0;
            if (INSTR_VALID) begin
                out_d.valid = 1'b1;
                case (opcode)
                    OP_LOADI: begin
                        out_d.data2     = imm;
                        out_d.dest_addr = addr_rd;
                        out_d.dest_we   = 1'b1;
                    end
                    OP_MOV: begin
                        out_d.data2     = val_rs;
                        out_d.dest_addr = addr_rd;
                        out_d.dest_we   = 1'b1;
                    end
                    OP_ADD, OP_AND, OP_OR: begin
                        out_d.data1     = val_rt;
                        out_d.data2     = val_rs;
                        out_d.aluop     = opcode == OP_ADD ? ALU_ADD : opcode == OP_AND ? ALU_AND : ALU_OR;
                        out_d.dest_addr = addr_rd;
                        out_d.dest_we   = 1'b1;
                    end
                    OP_SUB: begin
                        out_d.data1     = val_rt;
                        out_d.data2     = neg_rs;
                        out_d.aluop     = ALU_ADD;
                        out_d.dest_addr = addr_rd;
                        out_d.dest_we   = 1'b1;
                    end
                    OP_BEQ: begin
                        out_d.data1  = val_rt;
                        out_d.data2  = neg_rs;
                        out_d.aluop  = ALU_ADD;
                        out_d.branch = 1'b1;
                        out_d.offset = field_rd;
                    end
                    OP_J: begin
                        out_d.jump   = 1'b1;
                        out_d.offset = field_rd;
                    end
                    default: begin
                        out_d.valid   = 1'b0;
                        out_d.illegal = 1'b1;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) out_q <= '0;
        else       out_q <= out_d;
    end

    assign DATA1     = out_q.data1;
    assign DATA2     = out_q.data2;
    assign ALUOP     = out_q.aluop;
    assign DEST_ADDR = out_q.dest_addr;
    assign DEST_WE   = out_q.dest_we;
    assign BRANCH    = out_q.branch;
    assign JUMP      = out_q.jump;
    assign OFFSET    = out_q.offset;
    assign OUT_VALID = out_q.valid;
    assign ILLEGAL   = out_q.illegal;

endmodule

// File: tb/tb_operand_fetch_stage.sv
// tb_operand_fetch_stage: randomized and directed self-checking bench against a behavioural operand fetch model
module tb_operand_fetch_stage;

    logic        CLK = 1'b0;
    logic        RESET;
    logic [31:0] INSTRUCTION;
    logic        INSTR_VALID;
    logic        STALL;
    logic        WB_EN;
    logic [2:0]  WB_ADDR;
    logic [7:0]  WB_DATA;
    logic [7:0]  DATA1;
    logic [7:0]  DATA2;
    logic [2:0]  ALUOP;
    logic [2:0]  DEST_ADDR;
    logic        DEST_WE;
    logic        BRANCH;
    logic        JUMP;
    logic [7:0]  OFFSET;
    logic        OUT_VALID;
    logic        ILLEGAL;

    operand_fetch_stage dut (
        .CLK(CLK), .RESET(RESET), .INSTRUCTION(INSTRUCTION), .INSTR_VALID(INSTR_VALID),
        .STALL(STALL), .WB_EN(WB_EN), .WB_ADDR(WB_ADDR), .WB_DATA(WB_DATA),
        .DATA1(DATA1), .DATA2(DATA2), .ALUOP(ALUOP), .DEST_ADDR(DEST_ADDR),
        .DEST_WE(DEST_WE), .BRANCH(BRANCH), .JUMP(JUMP), .OFFSET(OFFSET),
        .OUT_VALID(OUT_VALID), .ILLEGAL(ILLEGAL)
    );

    always #5 CLK = ~CLK;

`ifdef OFS_ZERO_REG_EN
    localparam bit ZR = 1'b1;
`else
    localparam bit ZR = 1'b0;
`endif

    int total = 0;
    int bad = 0;
    int mregs [8];
    logic [34:0] exp_v;
    logic [34:0] obs;

    assign obs = {DATA1, DATA2, ALUOP, DEST_ADDR, DEST_WE, BRANCH, JUMP, OFFSET, OUT_VALID, ILLEGAL};

    function automatic int mread(input int a);
        if (ZR && a == 0) return 0;
        if (WB_EN && int'(WB_ADDR) == a) return int'(WB_DATA);
        return mregs[a];
    endfunction

    function automatic logic [7:0] mneg(input int v);
        return 8'((256 - v) % 256);
    endfunction

    function automatic logic [34:0] mdecode(input logic [31:0] ins);
        int op, t, s;
        logic [2:0] rd;
        logic [7:0] hi, lo;
        op = int'(ins[31:24]);
        hi = ins[23:16];
        lo = ins[7:0];
        rd = 3'(int'(hi) % 8);
        t = mread(int'(ins[15:8]) % 8);
        s = mread(int'(lo) % 8);
        case (op)
            0: return {8'h00, lo, 3'd0, rd, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0};
            1: return {8'h00, 8'(s), 3'd0, rd, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0};
            2: return {8'(t), 8'(s), 3'd1, rd, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0};
            3: return {8'(t), mneg(s), 3'd1, rd, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0};
            4: return {8'(t), 8'(s), 3'd2, rd, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0};
            5: return {8'(t), 8'(s), 3'd3, rd, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0};
            6: return {8'h00, 8'h00, 3'd0, 3'd0, 1'b0, 1'b0, 1'b1, hi, 1'b1, 1'b0};
            7: return {8'(t), mneg(s), 3'd1, 3'd0, 1'b0, 1'b1, 1'b0, hi, 1'b1, 1'b0};
            default: return 35'd1;
        endcase
    endfunction

    task automatic drive(input logic [31:0] ins, input logic v, input logic st,
                         input logic we, input logic [2:0] wa, input logic [7:0] wd);
        INSTRUCTION = ins;
        INSTR_VALID = v;
        STALL = st;
        WB_EN = we;
        WB_ADDR = wa;
        WB_DATA = wd;
    endtask

    task automatic clk_step();
        if (!STALL) exp_v = INSTR_VALID ? mdecode(INSTRUCTION) : '0;
        if (WB_EN && !(ZR && WB_ADDR == 3'd0)) mregs[WB_ADDR] = int'(WB_DATA);
        @(posedge CLK);
        #1;
    endtask

    task automatic model_reset();
        for (int i = 0; i < 8; i++) mregs[i] = 0;
        exp_v = '0;
    endtask

    task automatic test_reset();
        RESET = 1'b1;
        drive(32'h0, 1'b0, 1'b0, 1'b0, 3'd0, 8'h00);
        model_reset();
        #12;
        total++;
        if (obs !== 35'd0) begin bad++; $display("FAIL reset_outputs got=%h want=%h", obs, 35'd0); end
        @(negedge CLK);
        RESET = 1'b0;
        for (int i = 0; i < 8; i++) begin
            drive({8'd1, 8'd0, 8'd0, 8'(i)}, 1'b1, 1'b0, 1'b0, 3'd0, 8'h00);
            clk_step();
            total++;
            if (DATA2 !== 8'h00 || OUT_VALID !== 1'b1 || obs !== exp_v) begin
                bad++; $display("FAIL reset_reg%0d got=%h want=%h", i, obs, exp_v);
            end
        end
    endtask

    task automatic test_loadi();
        drive(32'h0002002A, 1'b1, 1'b0, 1'b0, 3'd0, 8'h00);
        clk_step();
        total++;
        if (obs !== {8'h00, 8'h2A, 3'd0, 3'd2, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0}) begin
            bad++; $display("FAIL loadi got=%h want DATA2=2a DEST=2 WE=1 VALID=1", obs);
        end
    endtask

    task automatic test_sub_beq();
        drive(32'h0, 1'b0, 1'b0, 1'b1, 3'd1, 8'h05);
        clk_step();
        drive(32'h0, 1'b0, 1'b0, 1'b1, 3'd2, 8'h03);
        clk_step();
        drive(32'h03040102, 1'b1, 1'b0, 1'b0, 3'd0, 8'h00);
        clk_step();
        total++;
        if (DATA1 !== 8'h05 || DATA2 !== 8'hFD || ALUOP !== 3'd1 || DEST_ADDR !== 3'd4 || obs !== exp_v) begin
            bad++; $display("FAIL sub got=%h want=%h", obs, exp_v);
        end
        drive(32'h07100101, 1'b1, 1'b0, 1'b0, 3'd0, 8'h00);
        clk_step();
        total++;
        if (BRANCH !== 1'b1 || DATA1 !== 8'h05 || DATA2 !== 8'hFB || ALUOP !== 3'd1 ||
            DEST_WE !== 1'b0 || OFFSET !== 8'h10 || obs !== exp_v) begin
            bad++; $display("FAIL beq got=%h want=%h", obs, exp_v);
        end
        drive(32'h06F70000, 1'b1, 1'b0, 1'b0, 3'd0, 8'h00);
        clk_step();
        total++;
        if (obs !== {16'h0000, 3'd0, 3'd0, 1'b0, 1'b0, 1'b1, 8'hF7, 1'b1, 1'b0}) begin
            bad++; $display("FAIL jump got=%h want=%h", obs, exp_v);
        end
    endtask

    task automatic test_bypass();
        drive(32'h02000303, 1'b1, 1'b0, 1'b1, 3'd3, 8'h7E);
        clk_step();
        total++;
        if (DATA1 !== 8'h7E || DATA2 !== 8'h7E || ALUOP !== 3'd1 || obs !== exp_v) begin
            bad++; $display("FAIL bypass got=%h want=%h", obs, exp_v);
        end
        drive(32'h030A0304, 1'b1, 1'b0, 1'b1, 3'd4, 8'h01);
        clk_step();
        total++;
        if (DATA1 !== 8'h7E || DATA2 !== 8'hFF || obs !== exp_v) begin
            bad++; $display("FAIL bypass_neg got=%h want=%h", obs, exp_v);
        end
    endtask

    task automatic test_negate_edges();
        drive(32'h0, 1'b0, 1'b0, 1'b1, 3'd7, 8'h80);
        clk_step();
        drive(32'h0, 1'b0, 1'b0, 1'b1, 3'd6, 8'h00);
        clk_step();
        drive(32'h03000707, 1'b1, 1'b0, 1'b0, 3'd0, 8'h00);
        clk_step();
        total++;
        if (DATA1 !== 8'h80 || DATA2 !== 8'h80 || obs !== exp_v) begin
            bad++; $display("FAIL neg_80 got=%h want=%h", obs, exp_v);
        end
        drive(32'h03F8FF06, 1'b1, 1'b0, 1'b0, 3'd0, 8'h00);
        clk_step();
        total++;
        if (DATA1 !== 8'h80 || DATA2 !== 8'h00 || DEST_ADDR !== 3'd0 || obs !== exp_v) begin
            bad++; $display("FAIL neg_00_hi_bits got=%h want=%h", obs, exp_v);
        end
    endtask

    task automatic test_stall();
        logic [34:0] snap;
        drive(32'h00050099, 1'b1, 1'b0, 1'b0, 3'd0, 8'h00);
        clk_step();
        snap = obs;
        for (int i = 0; i < 3; i++) begin
            drive({8'(i + 1), 8'($urandom), 8'($urandom), 8'($urandom)}, 1'b1, 1'b1,
                  i == 0, 3'd5, 8'h55);
            clk_step();
            total++;
            if (obs !== snap || obs !== exp_v) begin
                bad++; $display("FAIL stall_hold%0d got=%h want=%h", i, obs, snap);
            end
        end
        drive(32'h01010005, 1'b1, 1'b0, 1'b0, 3'd0, 8'h00);
        clk_step();
        total++;
        if (DATA2 !== 8'h55 || DEST_ADDR !== 3'd1 || OUT_VALID !== 1'b1 || obs !== exp_v) begin
            bad++; $display("FAIL stall_wb got=%h want=%h", obs, exp_v);
        end
    endtask

    task automatic test_illegal();
        drive(32'h09123456, 1'b1, 1'b0, 1'b0, 3'd0, 8'h00);
        clk_step();
        total++;
        if (OUT_VALID !== 1'b0 || ILLEGAL !== 1'b1 || obs !== 35'd1) begin
            bad++; $display("FAIL illegal09 got=%h want=%h", obs, 35'd1);
        end
        drive(32'h09123456, 1'b0, 1'b0, 1'b0, 3'd0, 8'h00);
        clk_step();
        total++;
        if (obs !== 35'd0) begin bad++; $display("FAIL bubble got=%h want=%h", obs, 35'd0); end
        drive(32'hFF000000, 1'b1, 1'b0, 1'b0, 3'd0, 8'h00);
        clk_step();
        total++;
        if (obs !== 35'd1) begin bad++; $display("FAIL illegalFF got=%h want=%h", obs, 35'd1); end
    endtask

    task automatic test_reset_mid_stall();
        drive(32'h00030011, 1'b1, 1'b0, 1'b0, 3'd0, 8'h00);
        clk_step();
        total++;
        if (OUT_VALID !== 1'b1) begin bad++; $display("FAIL pre_reset_valid got=%b want=1", OUT_VALID); end
        drive(32'h00030022, 1'b1, 1'b1, 1'b0, 3'd0, 8'h00);
        clk_step();
        #1;
        RESET = 1'b1;
        model_reset();
        #1;
        total++;
        if (obs !== 35'd0) begin bad++; $display("FAIL async_reset got=%h want=%h", obs, 35'd0); end
        #1;
        RESET = 1'b0;
        drive(32'h01060001, 1'b1, 1'b0, 1'b0, 3'd0, 8'h00);
        clk_step();
        total++;
        if (DATA2 !== 8'h00 || OUT_VALID !== 1'b1 || DEST_ADDR !== 3'd6 || obs !== exp_v) begin
            bad++; $display("FAIL post_reset_mov got=%h want=%h", obs, exp_v);
        end
    endtask

    task automatic test_random();
        int r;
        logic [7:0] op;
        for (int n = 0; n < 400; n++) begin
            r = $urandom_range(0, 19);
            op = r < 16 ? 8'(r % 8) : (r == 16 ? 8'hFF : 8'($urandom_range(8, 255)));
            drive({op, 8'($urandom), 8'($urandom), 8'($urandom)}, $urandom_range(0, 3) != 0,
                  $urandom_range(0, 3) == 0, $urandom_range(0, 1) == 1,
                  3'($urandom_range(0, 7)), 8'($urandom));
            clk_step();
            total++;
            if (obs !== exp_v) begin bad++; $display("FAIL random%0d got=%h want=%h", n, obs, exp_v); end
        end
    endtask

    initial begin
        test_reset();
        test_loadi();
        test_sub_beq();
        test_bypass();
        test_negate_edges();
        test_stall();
        test_illegal();
        test_reset_mid_stall();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
